// File: rtl/complete_bus_arbiter.sv
// rtl/complete_bus_arbiter.sv - round-robin arbiter for the shared completion bus
// One registered output stage; losers and stalled senders are rejected combinationally.
module complete_bus_arbiter #(
   parameter int N_REQ = 5,
   parameter int MSG_W = 80
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flash,
   input  logic [N_REQ-1:0]       req_en,
   input  logic [N_REQ*MSG_W-1:0] req_msg,
   output logic [N_REQ-1:0]       req_reject,
   output logic                   out_en,
   output logic [MSG_W-1:0]       out_msg,
   input  logic                   out_reject
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

   logic               out_valid;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   win;
   logic               found;
   logic               can_load;
   logic [MSG_W-1:0]   win_msg;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [PTR_W:0]     sum;

   assign can_load = ~out_valid | ~out_reject;
   assign out_en   = out_valid & ~flash;

   // Rotate requests so bit 0 is the requester at ptr; first set bit wins.
   assign dbl = {req_en, req_en} >> ptr;
   assign rot = dbl[N_REQ-1:0];

   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (PTR_W+1)'(k);
            win   = (sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                                               : PTR_W'(sum);
         end
      end
   end

   always_comb begin
      win_msg = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win == PTR_W'(i)) win_msg = req_msg[i*MSG_W +: MSG_W];
      end
   end

   // Flushed or resetting senders drop their requests, so nothing is rejected then.
   always_comb begin
      req_reject = '0;
      if (!reset && !flash) begin
         for (int i = 0; i < N_REQ; i++) begin
            req_reject[i] = req_en[i] & (~can_load | ~(found && (win == PTR_W'(i))));
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_msg   <= '0;
         ptr       <= '0;
      end else if (flash) begin
         out_valid <= 1'b0;
      end else if (can_load) begin
         if (found) begin
            out_valid <= 1'b1;
            out_msg   <= win_msg;
            ptr       <= (win == LAST) ? '0 : win + PTR_W'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_complete_bus_arbiter.sv
// tb/tb_complete_bus_arbiter.sv - randomized self-checking bench for complete_bus_arbiter
module tb_complete_bus_arbiter;
   localparam int N = 5;
   localparam int W = 16;

   logic           clock = 1'b0;
   logic           reset;
   logic           flash;
   logic           out_reject;
   logic [N-1:0]   req_en;
   logic [N*W-1:0] req_msg;
   logic [N-1:0]   req_reject;
   logic           out_en;
   logic [W-1:0]   out_msg;
   logic [W-1:0]   msg [N];

   int n_vec = 0;
   int n_err = 0;

   bit           m_valid;
   logic [W-1:0] m_msg;
   int           m_ptr;
   int           e_win;
   bit           e_can;
   logic [N-1:0] e_reject;
   logic         e_en;
   logic [W-1:0] e_msg;
   int           ld_win;

   always #5 clock = ~clock;

   always_comb begin
      req_msg = '0;
      for (int i = 0; i < N; i++) req_msg[i*W +: W] = msg[i];
   end

   complete_bus_arbiter #(.N_REQ(N), .MSG_W(W)) dut (
      .clock(clock), .reset(reset), .flash(flash), .req_en(req_en), .req_msg(req_msg),
      .req_reject(req_reject), .out_en(out_en), .out_msg(out_msg), .out_reject(out_reject)
   );

   task automatic model_eval();
      e_en  = m_valid && !flash;
      e_msg = m_msg;
      e_can = !m_valid || !out_reject;
      e_win = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (e_win < 0 && req_en[idx]) e_win = idx;
      end
      e_reject = '0;
      if (!reset && !flash)
         for (int i = 0; i < N; i++) e_reject[i] = req_en[i] && (!e_can || i != e_win);
   endtask

   task automatic model_update();
      model_eval();
      ld_win = -1;
      if (reset) begin
         m_valid = 1'b0; m_msg = '0; m_ptr = 0;
      end else if (flash) begin
         m_valid = 1'b0;
      end else if (e_can) begin
         if (e_win >= 0) begin
            m_valid = 1'b1; m_msg = msg[e_win]; m_ptr = (e_win + 1) % N; ld_win = e_win;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1; flash = 1'b0; out_reject = 1'b0; req_en = '0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      req_en = '0; flash = 1'b0; out_reject = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; flash = 1'b0; out_reject = 1'b0; req_en = '1;
      for (int i = 0; i < N; i++) msg[i] = 16'hA000 + 16'(i);
      tick(); tick();
      @(negedge clock);
      n_vec++; if (out_en !== 1'b0) begin n_err++; $display("FAIL reset_out_en: got %b want 0", out_en); end
      n_vec++; if (req_reject !== 5'b00000) begin n_err++; $display("FAIL reset_req_reject: got %b want 00000", req_reject); end
      n_vec++; if (out_msg !== 16'h0000) begin n_err++; $display("FAIL reset_out_msg: got %h want 0000", out_msg); end
      reset = 1'b0;
      #1;
      n_vec++; if (req_reject !== 5'b11110) begin n_err++; $display("FAIL reset_first_grant_reject: got %b want 11110", req_reject); end
      tick();
      @(negedge clock);
      n_vec++; if (out_en !== 1'b1 || out_msg !== 16'hA000) begin n_err++; $display("FAIL reset_first_grant: got en=%b msg=%h want en=1 msg=a000", out_en, out_msg); end
      drain();
   endtask

   task automatic test_single();
      reset_dut();
      req_en = 5'b00100; msg[2] = 16'hBEEF;
      @(negedge clock);
      n_vec++; if (req_reject !== 5'b00000) begin n_err++; $display("FAIL single_reject: got %b want 00000", req_reject); end
      tick();
      req_en = '1;
      for (int i = 0; i < N; i++) msg[i] = 16'hB000 + 16'(i);
      @(negedge clock);
      n_vec++; if (out_en !== 1'b1 || out_msg !== 16'hBEEF) begin n_err++; $display("FAIL single_out: got en=%b msg=%h want en=1 msg=beef", out_en, out_msg); end
      n_vec++; if (req_reject !== 5'b10111) begin n_err++; $display("FAIL single_ptr3: got %b want 10111", req_reject); end
      tick();
      @(negedge clock);
      n_vec++; if (out_msg !== 16'hB003) begin n_err++; $display("FAIL single_next: got %h want b003", out_msg); end
      drain();
   endtask

   task automatic test_wrap();
      reset_dut();
      req_en = 5'b01000; msg[3] = 16'h3333;
      tick();
      req_en = 5'b10001; msg[4] = 16'h4444; msg[0] = 16'h0A0A;
      @(negedge clock);
      n_vec++; if (req_reject !== 5'b00001) begin n_err++; $display("FAIL wrap_reject4: got %b want 00001", req_reject); end
      tick();
      @(negedge clock);
      n_vec++; if (out_msg !== 16'h4444) begin n_err++; $display("FAIL wrap_grant4: got %h want 4444", out_msg); end
      n_vec++; if (req_reject !== 5'b10000) begin n_err++; $display("FAIL wrap_reject0: got %b want 10000", req_reject); end
      tick();
      @(negedge clock);
      n_vec++; if (out_en !== 1'b1 || out_msg !== 16'h0A0A) begin n_err++; $display("FAIL wrap_grant0: got en=%b msg=%h want en=1 msg=0a0a", out_en, out_msg); end
      drain();
   endtask

   task automatic test_round_robin();
      int ord [6];
      logic [N-1:0] ex;
      ord = '{0, 1, 2, 3, 4, 0};
      reset_dut();
      req_en = '1;
      for (int i = 0; i < N; i++) msg[i] = 16'h5A00 + 16'(i);
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         ex = '1; ex[ord[c]] = 1'b0;
         n_vec++; if (req_reject !== ex) begin n_err++; $display("FAIL rr_reject_%0d: got %b want %b", c, req_reject, ex); end
         if (c > 0) begin
            n_vec++; if (out_en !== 1'b1 || out_msg !== 16'h5A00 + 16'(ord[c-1])) begin n_err++; $display("FAIL rr_grant_%0d: got en=%b msg=%h want en=1 msg=%h", c, out_en, out_msg, 16'h5A00 + 16'(ord[c-1])); end
         end
         tick();
      end
      @(negedge clock);
      n_vec++; if (out_en !== 1'b1 || out_msg !== 16'h5A00) begin n_err++; $display("FAIL rr_grant_last: got en=%b msg=%h want en=1 msg=5a00", out_en, out_msg); end
      drain();
   endtask

   task automatic test_backpressure();
      reset_dut();
      req_en = 5'b00001; msg[0] = 16'h0C0C;
      tick();
      out_reject = 1'b1; req_en = 5'b00010; msg[1] = 16'h1111;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         n_vec++; if (req_reject !== 5'b00010) begin n_err++; $display("FAIL bp_reject_%0d: got %b want 00010", c, req_reject); end
         n_vec++; if (out_en !== 1'b1 || out_msg !== 16'h0C0C) begin n_err++; $display("FAIL bp_hold_%0d: got en=%b msg=%h want en=1 msg=0c0c", c, out_en, out_msg); end
         tick();
      end
      out_reject = 1'b0;
      @(negedge clock);
      n_vec++; if (req_reject !== 5'b00000) begin n_err++; $display("FAIL bp_release_reject: got %b want 00000", req_reject); end
      tick();
      req_en = '0;
      @(negedge clock);
      n_vec++; if (out_en !== 1'b1 || out_msg !== 16'h1111) begin n_err++; $display("FAIL bp_release_out: got en=%b msg=%h want en=1 msg=1111", out_en, out_msg); end
      drain();
   endtask

   task automatic test_flash();
      reset_dut();
      req_en = 5'b00001; msg[0] = 16'h0F0F;
      tick();
      req_en = 5'b01000; flash = 1'b1; msg[3] = 16'h3F3F;
      @(negedge clock);
      n_vec++; if (out_en !== 1'b0) begin n_err++; $display("FAIL flash_out_en: got %b want 0", out_en); end
      n_vec++; if (req_reject !== 5'b00000) begin n_err++; $display("FAIL flash_reject: got %b want 00000", req_reject); end
      tick();
      flash = 1'b0; req_en = '0;
      @(negedge clock);
      n_vec++; if (out_en !== 1'b0) begin n_err++; $display("FAIL flash_after: got %b want 0", out_en); end
      req_en = '1;
      for (int i = 0; i < N; i++) msg[i] = 16'hF000 + 16'(i);
      #1;
      n_vec++; if (req_reject !== 5'b11101) begin n_err++; $display("FAIL flash_ptr: got %b want 11101", req_reject); end
      tick();
      req_en = '0;
      @(negedge clock);
      n_vec++; if (out_msg !== 16'hF001) begin n_err++; $display("FAIL flash_ptr_grant: got %h want f001", out_msg); end
      drain();
   endtask

   task automatic test_random();
      logic [N-1:0] pend;
      int wt [N];
      reset_dut();
      pend = '0;
      for (int i = 0; i < N; i++) wt[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               pend[i] = ($urandom % 3) == 0;
               msg[i]  = 16'($urandom);
               wt[i]   = 0;
            end
         end
         req_en = pend;
         out_reject = ($urandom % 4) == 0;
         flash = ($urandom % 20) == 0;
         @(negedge clock);
         model_eval();
         n_vec++; if (req_reject !== e_reject) begin n_err++; $display("FAIL rand_reject_%0d: got %b want %b", c, req_reject, e_reject); end
         n_vec++; if (out_en !== e_en) begin n_err++; $display("FAIL rand_out_en_%0d: got %b want %b", c, out_en, e_en); end
         if (e_en) begin
            n_vec++; if (out_msg !== e_msg) begin n_err++; $display("FAIL rand_out_msg_%0d: got %h want %h", c, out_msg, e_msg); end
         end
         tick();
         if (flash) begin
            pend = '0;
         end else if (ld_win >= 0) begin
            n_vec++; if (wt[ld_win] >= N) begin n_err++; $display("FAIL rand_fairness_%0d: req %0d waited %0d loads, limit %0d", c, ld_win, wt[ld_win], N - 1); end
            for (int j = 0; j < N; j++) if (pend[j] && j != ld_win) wt[j]++;
            pend[ld_win] = 1'b0;
         end
      end
      drain();
   endtask

   initial begin
      reset = 1'b1; flash = 1'b0; out_reject = 1'b0; req_en = '0;
      for (int i = 0; i < N; i++) msg[i] = '0;
      m_valid = 1'b0; m_msg = '0; m_ptr = 0; ld_win = -1;
      test_reset();
      test_single();
      test_wrap();
      test_round_robin();
      test_backpressure();
      test_flash();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
